// File: rtl/alu_sequencer_pkg.sv
// Shared types for the byte-serial ALU sequencer: opcodes, per-operation
// control bundle, FSM states and the opcode decoder.
package alu_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_INC = 4'd8,
    OP_DEC = 4'd9,
    OP_SHR = 4'd10,
    OP_SAR = 4'd11,
    OP_CMP = 4'd12,
    OP_MOV = 4'd13
  } op_e;

  // Where the carry-in of the first processed byte comes from.
  typedef enum logic [1:0] {
    CI_ZERO = 2'd0,
    CI_ONE  = 2'd1,
    CI_CFQ  = 2'd2
  } ci_sel_e;

  // How the final carry flag is formed.
  typedef enum logic [1:0] {
    CF_ARITH = 2'd0,
    CF_ZERO  = 2'd1,
    CF_SHIFT = 2'd2
  } cf_mode_e;

  typedef struct packed {
    logic     nb;
    logic     ic;
    logic     na;
    logic     xo;
    logic     no;
    logic     sr;
    logic     ss_top;
    ci_sel_e  ci_sel;
    logic     force_b0;
    logic     keep_a;
    logic     msb_first;
    cf_mode_e cf_mode;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Opcode to ALU control lines; opcodes 13-15 all behave as MOV.
  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c.nb        = 1'b0;
    c.ic        = 1'b0;
    c.na        = 1'b0;
    c.xo        = 1'b0;
    c.no        = 1'b0;
    c.sr        = 1'b0;
    c.ss_top    = 1'b0;
    c.ci_sel    = CI_ZERO;
    c.force_b0  = 1'b0;
    c.keep_a    = 1'b0;
    c.msb_first = 1'b0;
    c.cf_mode   = CF_ARITH;
    case (op)
      OP_ADD: c.ci_sel = CI_ZERO;
      OP_ADC: c.ci_sel = CI_CFQ;
      OP_SUB: begin
        c.nb     = 1'b1;
        c.ci_sel = CI_ONE;
      end
      OP_SBB: begin
        c.nb     = 1'b1;
        c.ci_sel = CI_CFQ;
      end
      OP_AND: begin
        c.na      = 1'b1;
        c.nb      = 1'b1;
        c.xo      = 1'b1;
        c.no      = 1'b1;
        c.ic      = 1'b1;
        c.cf_mode = CF_ZERO;
      end
      OP_OR: begin
        c.xo      = 1'b1;
        c.ic      = 1'b1;
        c.cf_mode = CF_ZERO;
      end
      OP_XOR: begin
        c.ic      = 1'b1;
        c.cf_mode = CF_ZERO;
      end
      OP_NOT: begin
        c.force_b0 = 1'b1;
        c.na       = 1'b1;
        c.ic       = 1'b1;
        c.cf_mode  = CF_ZERO;
      end
      OP_INC: begin
        c.force_b0 = 1'b1;
        c.ci_sel   = CI_ONE;
      end
      OP_DEC: begin
        c.force_b0 = 1'b1;
        c.nb       = 1'b1;
        c.ci_sel   = CI_ZERO;
      end
      OP_SHR: begin
        c.force_b0  = 1'b1;
        c.sr        = 1'b1;
        c.ic        = 1'b1;
        c.msb_first = 1'b1;
        c.cf_mode   = CF_SHIFT;
      end
      OP_SAR: begin
        c.force_b0  = 1'b1;
        c.sr        = 1'b1;
        c.ic        = 1'b1;
        c.ss_top    = 1'b1;
        c.msb_first = 1'b1;
        c.cf_mode   = CF_SHIFT;
      end
      OP_CMP: begin
        c.nb     = 1'b1;
        c.ci_sel = CI_ONE;
        c.keep_a = 1'b1;
      end
      default: begin
        c.force_b0 = 1'b1;
        c.ic       = 1'b1;
        c.cf_mode  = CF_ZERO;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// 8-bit combinational ALU slice: optional operand inversion, add with carry,
// OR/XOR logic (carry inhibited), one-bit right shift, optional output
// inversion. AND is built as NOT(NOT a OR NOT b).
module alu_sequencer_alu (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_ci,
  input  logic       i_nb,
  input  logic       i_ic,
  input  logic       i_na,
  input  logic       i_xo,
  input  logic       i_no,
  input  logic       i_sr,
  input  logic       i_ss,
  output logic [7:0] o_y,
  output logic       o_co,
  output logic       o_zf
);

  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [8:0] w_sum;
  logic [7:0] w_pre;
  logic       w_co_pre;

  // Byte datapath: shift has priority, then carry-inhibited logic, else add.
  always_comb begin
    w_a      = i_na ? ~i_a : i_a;
    w_b      = i_nb ? ~i_b : i_b;
    w_sum    = {1'b0, w_a} + {1'b0, w_b} + {8'h00, i_ci};
    w_pre    = 8'h00;
    w_co_pre = 1'b0;
    if (i_sr) begin
      w_pre    = {i_ss & i_a[7], i_a[7:1]};
      w_co_pre = i_a[0];
    end else if (i_ic) begin
      w_pre    = i_xo ? (w_a | w_b) : (w_a ^ w_b);
      w_co_pre = 1'b0;
    end else begin
      w_pre    = w_sum[7:0];
      w_co_pre = w_sum[8];
    end
    o_y  = i_no ? ~w_pre : w_pre;
    o_co = w_co_pre;
    o_zf = (o_y == 8'h00);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Byte-serial multi-precision ALU sequencer. One operation at a time is
// accepted in IDLE, walked one byte per cycle through a single 8-bit ALU
// slice in EXEC, and presented with flags in DONE until consumed.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_result,
  output logic                rsp_cf,
  output logic                rsp_sf,
  output logic                rsp_zf
);

  localparam int         W        = 8 * NBYTES;
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  state_e         r_state;
  state_e         w_state_next;
  ctrl_t          r_ctrl;
  ctrl_t          w_ctrl_req;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic [3:0]     r_idx;
  logic           r_carry;
  logic           r_zf_acc;
  logic           r_sf_acc;
  logic           r_cf_q;
  logic           r_req_ready;
  logic           r_rsp_valid;
  logic [W-1:0]   r_rsp_result;
  logic           r_rsp_cf;
  logic           r_rsp_sf;
  logic           r_rsp_zf;

  logic           w_accept;
  logic [7:0]     w_a_byte;
  logic [7:0]     w_b_byte;
  logic           w_a_above_lsb;
  logic           w_is_top;
  logic           w_is_bottom;
  logic           w_is_first;
  logic           w_is_last;
  logic           w_alu_ci;
  logic           w_alu_ss;
  logic [7:0]     w_alu_y;
  logic           w_alu_co;
  logic           w_alu_zf;
  logic           w_override;
  logic [7:0]     w_byte_out;
  logic           w_byte_zf;
  logic [W-1:0]   w_res_next;
  logic           w_zf_final;
  logic           w_sf_final;
  logic           w_cf_final;

  assign w_accept   = req_valid && r_req_ready;
  assign w_ctrl_req = decode_op(req_op);

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_cf     = r_rsp_cf;
  assign rsp_sf     = r_rsp_sf;
  assign rsp_zf     = r_rsp_zf;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: accept in IDLE, leave EXEC after the last byte, leave
  // DONE on the response handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_EXEC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (w_is_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_req_ready <= (w_state_next == ST_IDLE);
      r_rsp_valid <= (w_state_next == ST_DONE);
    end
  end

  // Select the operand bytes at the current index, plus bit 0 of the A byte
  // above it (the bit a right shift moves into this byte's MSB).
  always_comb begin
    w_a_byte      = 8'h00;
    w_b_byte      = 8'h00;
    w_a_above_lsb = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      w_a_byte = w_a_byte | ((r_idx == 4'(i)) ? r_a[i*8 +: 8] : 8'h00);
      w_b_byte = w_b_byte | ((r_idx == 4'(i)) ? r_b[i*8 +: 8] : 8'h00);
    end
    for (int i = 0; i < NBYTES - 1; i++) begin
      w_a_above_lsb = w_a_above_lsb | ((r_idx == 4'(i)) & r_a[(i+1)*8]);
    end
    if (r_ctrl.force_b0) begin
      w_b_byte = 8'h00;
    end else begin
      w_b_byte = w_b_byte;
    end
  end

  // Byte position and carry-in: the op-specific carry feeds only the first
  // processed byte, later bytes chain the carry of the previous byte.
  always_comb begin
    w_is_top    = (r_idx == LAST_IDX);
    w_is_bottom = (r_idx == 4'd0);
    w_is_first  = r_ctrl.msb_first ? w_is_top : w_is_bottom;
    w_is_last   = r_ctrl.msb_first ? w_is_bottom : w_is_top;
    w_alu_ss    = r_ctrl.ss_top & w_is_top;
    w_alu_ci    = r_carry;
    if (w_is_first) begin
      case (r_ctrl.ci_sel)
        CI_ZERO: w_alu_ci = 1'b0;
        CI_ONE:  w_alu_ci = 1'b1;
        CI_CFQ:  w_alu_ci = r_cf_q;
        default: w_alu_ci = 1'b0;
      endcase
    end else begin
      w_alu_ci = r_carry;
    end
  end

  alu_sequencer_alu u_alu (
    .i_a  (w_a_byte),
    .i_b  (w_b_byte),
    .i_ci (w_alu_ci),
    .i_nb (r_ctrl.nb),
    .i_ic (r_ctrl.ic),
    .i_na (r_ctrl.na),
    .i_xo (r_ctrl.xo),
    .i_no (r_ctrl.no),
    .i_sr (r_ctrl.sr),
    .i_ss (w_alu_ss),
    .o_y  (w_alu_y),
    .o_co (w_alu_co),
    .o_zf (w_alu_zf)
  );

  // Post-ALU byte: shifts below the top byte take their MSB from the byte
  // above; merge the byte into the running result and fold the flags.
  always_comb begin
    w_override = r_ctrl.sr & ~w_is_top;
    w_byte_out = w_override ? {w_a_above_lsb, w_alu_y[6:0]} : w_alu_y;
    w_byte_zf  = w_override ? (w_byte_out == 8'h00) : w_alu_zf;
    w_res_next = r_res;
    for (int i = 0; i < NBYTES; i++) begin
      w_res_next[i*8 +: 8] = (r_idx == 4'(i)) ? w_byte_out : r_res[i*8 +: 8];
    end
    w_zf_final = w_is_first ? w_byte_zf : (r_zf_acc & w_byte_zf);
    w_sf_final = w_is_top ? w_byte_out[7] : r_sf_acc;
    w_cf_final = (r_ctrl.cf_mode == CF_ZERO) ? 1'b0 : w_alu_co;
  end

  // Operand capture on accept, byte walk during EXEC, and response/flag
  // update on the last byte so the outputs stay stable through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl       <= {$bits(ctrl_t){1'b0}};
      r_a          <= {W{1'b0}};
      r_b          <= {W{1'b0}};
      r_res        <= {W{1'b0}};
      r_idx        <= 4'd0;
      r_carry      <= 1'b0;
      r_zf_acc     <= 1'b0;
      r_sf_acc     <= 1'b0;
      r_cf_q       <= 1'b0;
      r_rsp_result <= {W{1'b0}};
      r_rsp_cf     <= 1'b0;
      r_rsp_sf     <= 1'b0;
      r_rsp_zf     <= 1'b0;
    end else if (w_accept) begin
      r_ctrl  <= w_ctrl_req;
      r_a     <= req_a;
      r_b     <= req_b;
      r_res   <= {W{1'b0}};
      r_idx   <= w_ctrl_req.msb_first ? LAST_IDX : 4'd0;
      r_carry <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_res    <= w_res_next;
      r_carry  <= w_alu_co;
      r_zf_acc <= w_zf_final;
      r_sf_acc <= w_sf_final;
      r_idx    <= r_ctrl.msb_first ? (r_idx - 4'd1) : (r_idx + 4'd1);
      if (w_is_last) begin
        r_rsp_result <= r_ctrl.keep_a ? r_a : w_res_next;
        r_rsp_cf     <= w_cf_final;
        r_rsp_sf     <= w_sf_final;
        r_rsp_zf     <= w_zf_final;
        r_cf_q       <= w_cf_final;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (NBYTES=4): a word-level reference model
// feeds a scoreboard checked every cycle a response is presented, plus
// hand-computed literal expectations for each directed operation.
module tb_alu_sequencer;

  typedef struct {
    logic [31:0] res;
    logic        cf;
    logic        sf;
    logic        zf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_cf;
  logic        rsp_sf;
  logic        rsp_zf;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic model_cfq = 1'b0;

  alu_sequencer #(.NBYTES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cf     (rsp_cf),
    .rsp_sf     (rsp_sf),
    .rsp_zf     (rsp_zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level reference: plain 64-bit arithmetic on the whole operands.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic cfq);
    exp_t        e;
    longint      ua;
    longint      ub;
    longint      s;
    longint      d;
    logic [31:0] fw;
    ua = longint'(a);
    ub = longint'(b);
    s  = 64'sd0;
    d  = 64'sd0;
    e.cf = 1'b0;
    case (op)
      4'd0:  begin s = ua + ub;               e.res = s[31:0]; e.cf = s[32]; end
      4'd1:  begin s = ua + ub + longint'(cfq); e.res = s[31:0]; e.cf = s[32]; end
      4'd2:  begin d = ua - ub;               e.res = d[31:0]; e.cf = (d >= 0); end
      4'd3:  begin d = ua - ub - (cfq ? 64'sd0 : 64'sd1); e.res = d[31:0]; e.cf = (d >= 0); end
      4'd4:  e.res = a & b;
      4'd5:  e.res = a | b;
      4'd6:  e.res = a ^ b;
      4'd7:  e.res = ~a;
      4'd8:  begin s = ua + 64'sd1;           e.res = s[31:0]; e.cf = s[32]; end
      4'd9:  begin d = ua - 64'sd1;           e.res = d[31:0]; e.cf = (d >= 0); end
      4'd10: begin e.res = a >> 1;            e.cf = a[0]; end
      4'd11: begin e.res = $signed(a) >>> 1;  e.cf = a[0]; end
      4'd12: begin d = ua - ub;               e.res = a; e.cf = (d >= 0); end
      default: e.res = a;
    endcase
    fw   = (op == 4'd12) ? d[31:0] : e.res;
    e.sf = fw[31];
    e.zf = (fw == 32'h0);
    return e;
  endfunction

  // Scoreboard: every cycle a response is presented it must match the oldest
  // outstanding expectation; it retires when the consumer accepts it.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (t=%0t)", $time);
      end else begin
        chk("sb_result", {32'h0, rsp_result}, {32'h0, exp_q[0].res});
        chk("sb_cf", {63'h0, rsp_cf}, {63'h0, exp_q[0].cf});
        chk("sb_sf", {63'h0, rsp_sf}, {63'h0, exp_q[0].sf});
        chk("sb_zf", {63'h0, rsp_zf}, {63'h0, exp_q[0].zf});
        chk("sb_req_ready_low", {63'h0, req_ready}, 64'h0);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One request/response transaction with literal expectations; 'hold' keeps
  // rsp_ready low that many cycles while a stray request is presented.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e_res, input logic e_cf,
                       input logic e_sf, input logic e_zf, input int hold);
    int   lat;
    int   w;
    exp_t m;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, "_ready_wait"}, {63'h0, req_ready}, 64'h1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    m = model(op, a, b, model_cfq);
    model_cfq = m.cf;
    exp_q.push_back(m);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_op    = 4'($urandom_range(0, 15));
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd4);
    chk({name, "_result"}, {32'h0, rsp_result}, {32'h0, e_res});
    chk({name, "_cf"}, {63'h0, rsp_cf}, {63'h0, e_cf});
    chk({name, "_sf"}, {63'h0, rsp_sf}, {63'h0, e_sf});
    chk({name, "_zf"}, {63'h0, rsp_zf}, {63'h0, e_zf});
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, {63'h0, rsp_valid}, 64'h1);
      chk({name, "_hold_result"}, {32'h0, rsp_result}, {32'h0, e_res});
      chk({name, "_hold_req_ready"}, {63'h0, req_ready}, 64'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_after_hs_valid"}, {63'h0, rsp_valid}, 64'h0);
    chk({name, "_after_hs_ready"}, {63'h0, req_ready}, 64'h1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {63'h0, req_ready}, 64'h1);
    chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("reset_result", {32'h0, rsp_result}, 64'h0);
    chk("reset_flags", {61'h0, rsp_cf, rsp_sf, rsp_zf}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_carry_byte", 4'd0,  32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, 0);
    do_op("add_wrap",       4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 0);
    do_op("adc_chain",      4'd1,  32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 0);
    do_op("sub_borrow",     4'd2,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 0);
    do_op("sbb_chain",      4'd3,  32'h00000005, 32'h00000000, 32'h00000004, 1'b1, 1'b0, 1'b0, 0);
    do_op("cmp_equal",      4'd12, 32'h00000007, 32'h00000007, 32'h00000007, 1'b1, 1'b0, 1'b1, 0);
    do_op("shr",            4'd10, 32'h80000003, 32'hDEADBEEF, 32'h40000001, 1'b1, 1'b0, 1'b0, 0);
    do_op("sar",            4'd11, 32'h80000003, 32'h00000000, 32'hC0000001, 1'b1, 1'b1, 1'b0, 0);
    do_op("and",            4'd4,  32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0, 1'b0, 1'b0, 0);
    do_op("or",             4'd5,  32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 1'b0, 1'b1, 1'b0, 0);
    do_op("xor",            4'd6,  32'hF0F01234, 32'h0FF0FF00, 32'hFF00ED34, 1'b0, 1'b1, 1'b0, 0);
    do_op("not",            4'd7,  32'h0000FFFF, 32'h00005555, 32'hFFFF0000, 1'b0, 1'b1, 1'b0, 0);
    do_op("inc_wrap",       4'd8,  32'hFFFFFFFF, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1, 0);
    do_op("dec_borrow",     4'd9,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 0);
    do_op("mov_op15",       4'd15, 32'h12345678, 32'h00000009, 32'h12345678, 1'b0, 1'b0, 1'b0, 0);
    do_op("stall_add",      4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 3);

    // Abort an ADD mid-EXEC with reset; no response may follow and the
    // carry set by the previous ADD must be cleared.
    req_op    = 4'd0;
    req_a     = 32'h00000001;
    req_b     = 32'h00000002;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_accepted", {63'h0, req_ready}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("abort_req_ready", {63'h0, req_ready}, 64'h1);
    chk("abort_result", {32'h0, rsp_result}, 64'h0);
    exp_q.delete();
    model_cfq = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_rsp", {63'h0, rsp_valid}, 64'h0);
    do_op("adc_after_reset", 4'd1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
